inv_mix_cols: RTL and testbench

//  AES InvMixColumns stage for the decryption datapath; the inverse of mix_cols.

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/inv_mix_column.sv | 24 ++
 rtl/inv_mix_cols.sv | 125 ++++++++++++
 tb/tb_inv_mix_cols.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) arithmetic helpers used by the column transforms.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } imc_state_t;

    localparam aes_byte_t AES_POLY = 8'h1B;

    // Multiply by 02: shift left and fold the carried-out x^8 back with 0x1B.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic aes_byte_t gf_mul9(input aes_byte_t b);
        aes_byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic aes_byte_t gf_mulb(input aes_byte_t b);
        aes_byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic aes_byte_t gf_muld(input aes_byte_t b);
        aes_byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic aes_byte_t gf_mule(input aes_byte_t b);
        aes_byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns transform of one 32-bit column (byte 0 is the MSB).
module inv_mix_column
    import aes_pkg::*;
(
    input  aes_col_t col,
    output aes_col_t result
);

    aes_byte_t a0, a1, a2, a3;
    aes_byte_t r0, r1, r2, r3;

    always_comb begin
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
        r1 = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
        r2 = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
        r3 = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
        result = {r0, r1, r2, r3};
    end

endmodule

// File: rtl/inv_mix_cols.sv
// Iterative AES InvMixColumns: COLS_PER_CYCLE columns per clock, one o_en pulse per block.
//   state   | meaning
//   ST_IDLE | waiting for i_en; data_out holds the last result
//   ST_BUSY | stepping col_cnt through the latched block
module inv_mix_cols
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic         i_en,
    output logic [127:0] data_out,
    output logic         o_en,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
            $error("inv_mix_cols: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // With four columns per cycle the step wraps to 0 and col_cnt stays at 0.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

    imc_state_t state, state_next;
    logic [1:0] col_cnt;
    aes_state_t in_reg;
    aes_state_t res_next;
    aes_col_t   in_cols   [4];
    aes_col_t   res_cols  [4];
    aes_col_t   next_cols [4];
    aes_col_t   col_in    [COLS_PER_CYCLE];
    aes_col_t   col_out   [COLS_PER_CYCLE];
    logic       load, step, done;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_cols[i] = in_reg[127 - 32*i -: 32];
        end
    end

    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
            logic [1:0] col_idx;
            assign col_idx   = col_cnt + 2'(g);
            assign col_in[g] = in_cols[col_idx];
            inv_mix_column u_col (
                .col    (col_in[g]),
                .result (col_out[g])
            );
        end
    endgenerate

    always_comb begin
        next_cols = res_cols;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            next_cols[col_cnt + 2'(g)] = col_out[g];
        end
        res_next = {next_cols[0], next_cols[1], next_cols[2], next_cols[3]};
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_en) begin
                    load       = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                step = 1'b1;
                if (col_cnt == COL_LAST) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt  <= '0;
            in_reg   <= '0;
            data_out <= '0;
            o_en     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                res_cols[i] <= '0;
            end
        end else begin
            o_en <= done;
            if (load) begin
                in_reg  <= data_in;
                col_cnt <= '0;
            end
            if (step) begin
                res_cols <= next_cols;
                col_cnt  <= col_cnt + COL_STEP;
            end
            // The last step's columns come straight from next_cols, not res_cols.
            if (done) begin
                data_out <= res_next;
            end
        end
    end

    assign busy = (state == ST_BUSY);

endmodule

// File: tb/tb_inv_mix_cols.sv
// Bench for inv_mix_cols: three instances (1, 2, 4 columns/cycle) share stimulus and
// are checked against a generic GF(2^8) matrix model.
module tb_inv_mix_cols;

    logic         clk;
    logic         rst;
    logic [127:0] data_in;
    logic         i_en;
    logic [127:0] dout [3];
    logic         oen  [3];
    logic         bsy  [3];

    int nn [3] = '{4, 2, 1};
    logic [127:0] exp_out [3];
    int tests_run = 0;
    int failed    = 0;

    inv_mix_cols #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst(rst), .data_in(data_in), .i_en(i_en),
        .data_out(dout[0]), .o_en(oen[0]), .busy(bsy[0])
    );
    inv_mix_cols #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst(rst), .data_in(data_in), .i_en(i_en),
        .data_out(dout[1]), .o_en(oen[1]), .busy(bsy[1])
    );
    inv_mix_cols #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst(rst), .data_in(data_in), .i_en(i_en),
        .data_out(dout[2]), .o_en(oen[2]), .busy(bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic shift-and-add GF(2^8) multiply, polynomial 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product on every column; inv selects InvMixColumns vs MixColumns.
    function automatic logic [127:0] mat_apply(input logic [127:0] s, input logic inv);
        logic [7:0]   row0 [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (inv) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(row0[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
                end
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        i_en = 1'b0;
        data_in = rand128();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if (dout[d] !== 128'h0 || oen[d] !== 1'b0 || bsy[d] !== 1'b0) begin
                failed++;
                $display("FAIL reset c%0d: data_out=%h o_en=%b busy=%b expected 0 0 0",
                         d, dout[d], oen[d], bsy[d]);
            end
            exp_out[d] = '0;
        end
        rst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                tests_run++;
                if (oen[d] !== 1'b0 || dout[d] !== 128'h0) begin
                    failed++;
                    $display("FAIL reset_idle c%0d cycle %0d: o_en=%b data_out=%h expected 0",
                             d, t, oen[d], dout[d]);
                end
            end
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] x;
        logic [127:0] want;
        x    = 128'h2cfaee30f8e08480064389704477d44a;
        want = 128'hf69f2445df4f9b17ad2b417be66c3710;
        data_in = x;
        i_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_en = 1'b0;
        data_in = rand128();
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                tests_run++;
                if (oen[d] !== (t == nn[d]) || bsy[d] !== (t < nn[d])) begin
                    failed++;
                    $display("FAIL round_trip_timing c%0d t=%0d: o_en=%b busy=%b expected %b %b",
                             d, t, oen[d], bsy[d], (t == nn[d]), (t < nn[d]));
                end
                if (t == nn[d]) exp_out[d] = want;
                tests_run++;
                if (dout[d] !== exp_out[d]) begin
                    failed++;
                    $display("FAIL round_trip c%0d t=%0d: data_out=%h expected %h",
                             d, t, dout[d], exp_out[d]);
                end
            end
        end
    endtask

    task automatic test_known_cols();
        logic [127:0] want;
        want = 128'hdb135345f20a225cc6c6c6c6d4d4d4d5;
        data_in = 128'h8e4da1bc9fdc589dc6c6c6c6d5d5d7d6;
        i_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_en = 1'b0;
        data_in = rand128();
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                tests_run++;
                if (oen[d] !== (t == nn[d])) begin
                    failed++;
                    $display("FAIL known_cols_oen c%0d t=%0d: o_en=%b expected %b",
                             d, t, oen[d], (t == nn[d]));
                end
                if (t == nn[d]) exp_out[d] = want;
                tests_run++;
                if (dout[d] !== exp_out[d]) begin
                    failed++;
                    $display("FAIL known_cols c%0d t=%0d: data_out=%h expected %h",
                             d, t, dout[d], exp_out[d]);
                end
            end
        end
    endtask

    // Held i_en: a block accepted at edge a completes at edge a+N, and the next
    // acceptance is the edge after, so acceptances fall on multiples of N+1.
    task automatic test_back_to_back();
        logic [127:0] hist [0:31];
        int last_acc;
        int a;
        bit hit;
        last_acc = 20;
        i_en = 1'b1;
        for (int e = 0; e <= last_acc + 5; e++) begin
            if (e > last_acc) i_en = 1'b0;
            data_in = rand128();
            hist[e] = data_in;
            @(posedge clk);
            @(negedge clk);
            if (e == 0) continue;
            for (int d = 0; d < 3; d++) begin
                a = e - nn[d];
                hit = (a >= 0) && (a <= last_acc) && (a % (nn[d] + 1) == 0);
                tests_run++;
                if (oen[d] !== hit) begin
                    failed++;
                    $display("FAIL back_to_back_oen c%0d edge %0d: o_en=%b expected %b",
                             d, e, oen[d], hit);
                end
                if (hit) exp_out[d] = mat_apply(hist[a], 1'b1);
                tests_run++;
                if (dout[d] !== exp_out[d]) begin
                    failed++;
                    $display("FAIL back_to_back c%0d edge %0d: data_out=%h expected %h",
                             d, e, dout[d], exp_out[d]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_block();
        logic [127:0] x;
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if (bsy[d] !== 1'b0) begin
                failed++;
                $display("FAIL reset_mid_pre c%0d: busy=%b expected 0", d, bsy[d]);
            end
        end
        data_in = rand128();
        i_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_en = 1'b0;
        for (int d = 0; d < 3; d++) begin
            if (nn[d] == 1) exp_out[d] = mat_apply(data_in, 1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if (oen[d] !== (nn[d] == 1) || dout[d] !== exp_out[d]) begin
                failed++;
                $display("FAIL reset_mid_edge1 c%0d: o_en=%b data_out=%h expected %b %h",
                         d, oen[d], dout[d], (nn[d] == 1), exp_out[d]);
            end
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            exp_out[d] = '0;
            tests_run++;
            if (oen[d] !== 1'b0 || dout[d] !== 128'h0 || bsy[d] !== 1'b0) begin
                failed++;
                $display("FAIL reset_mid c%0d: o_en=%b data_out=%h busy=%b expected 0 0 0",
                         d, oen[d], dout[d], bsy[d]);
            end
        end
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                tests_run++;
                if (oen[d] !== 1'b0) begin
                    failed++;
                    $display("FAIL reset_mid_quiet c%0d: o_en=%b expected 0", d, oen[d]);
                end
            end
        end
        x = rand128();
        data_in = x;
        i_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_en = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (t == nn[d]) begin
                    exp_out[d] = mat_apply(x, 1'b1);
                    tests_run++;
                    if (oen[d] !== 1'b1 || dout[d] !== exp_out[d]) begin
                        failed++;
                        $display("FAIL reset_mid_recover c%0d: o_en=%b data_out=%h expected 1 %h",
                                 d, oen[d], dout[d], exp_out[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] x;
        logic [127:0] want;
        for (int n = 0; n < 1000; n++) begin
            x = rand128();
            want = mat_apply(x, 1'b1);
            data_in = x;
            i_en = 1'b1;
            @(posedge clk);
            @(negedge clk);
            i_en = 1'b0;
            data_in = rand128();
            for (int t = 1; t <= 4; t++) begin
                @(posedge clk);
                @(negedge clk);
                for (int d = 0; d < 3; d++) begin
                    tests_run++;
                    if (oen[d] !== (t == nn[d])) begin
                        failed++;
                        $display("FAIL random_oen c%0d iter %0d t=%0d: o_en=%b expected %b",
                                 d, n, t, oen[d], (t == nn[d]));
                    end
                    if (t == nn[d]) begin
                        tests_run++;
                        if (dout[d] !== want) begin
                            failed++;
                            $display("FAIL random_model c%0d iter %0d: data_out=%h expected %h",
                                     d, n, dout[d], want);
                        end
                        tests_run++;
                        if (mat_apply(dout[d], 1'b0) !== x) begin
                            failed++;
                            $display("FAIL random_roundtrip c%0d iter %0d: mix_cols(data_out)=%h expected %h",
                                     d, n, mat_apply(dout[d], 1'b0), x);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_en = 1'b0;
        data_in = '0;
        test_reset();
        test_round_trip();
        test_known_cols();
        test_back_to_back();
        test_reset_mid_block();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
